// File: rtl/key_block_dispatcher.sv
// On-demand key-block dispatcher for parallel arcfour cracking cores.
// Round-robin arbitration over registered requests; issues one block of 2**BLOCK_LOG keys per grant.
module key_block_dispatcher #(
  parameter int unsigned          NUM_CORES     = 69,
  parameter int unsigned          LOG_NUM_CORES = 8,
  parameter int unsigned          KEY_WIDTH     = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX       = 24'hffffff,
  parameter int unsigned          BLOCK_LOG     = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     kill,
  input  logic [NUM_CORES-1:0]     req,
  output logic [NUM_CORES-1:0]     grant,
  output logic [KEY_WIDTH-1:0]     grant_base,
  output logic [KEY_WIDTH-1:0]     grant_last,
  output logic [LOG_NUM_CORES-1:0] grant_core,
  output logic                     busy,
  output logic                     exhausted,
  output logic [KEY_WIDTH-1:0]     blocks_issued
);

  localparam logic [KEY_WIDTH:0] One       = {{KEY_WIDTH{1'b0}}, 1'b1};
  localparam logic [KEY_WIDTH:0] BlockSize = One << BLOCK_LOG;
  localparam logic [KEY_WIDTH:0] BlockM1   = BlockSize - One;
  localparam logic [KEY_WIDTH:0] KeyMaxExt = {1'b0, KEY_MAX};
  localparam logic [LOG_NUM_CORES-1:0] LastCore = LOG_NUM_CORES'(NUM_CORES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q, state_d;
  logic [KEY_WIDTH:0]       next_key_q, next_key_d;
  logic [LOG_NUM_CORES-1:0] rr_q, rr_d;
  logic [NUM_CORES-1:0]     req_q;

  logic [NUM_CORES-1:0]     grant_d;
  logic [KEY_WIDTH-1:0]     base_d, last_d, issued_d;
  logic [LOG_NUM_CORES-1:0] core_d;
  logic                     exh_d;

  logic [NUM_CORES-1:0]     avail;
  logic                     found_hi, found_lo, found;
  logic [LOG_NUM_CORES-1:0] win_hi, win_lo, winner;
  logic [KEY_WIDTH:0]       block_end;
  logic                     is_final;

  // Last cycle's grantee is masked so a late-dropping request is not served twice.
  assign avail     = req_q & ~grant;
  assign block_end = next_key_q + BlockM1;
  assign is_final  = (block_end >= KeyMaxExt);

  // Descending scan: the last hit is the lowest index in each half of the rotation.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (avail[j]) begin
        if (j >= int'(rr_q)) begin
          found_hi = 1'b1;
          win_hi   = LOG_NUM_CORES'(j);
        end else begin
          found_lo = 1'b1;
          win_lo   = LOG_NUM_CORES'(j);
        end
      end
    end
    found  = found_hi | found_lo;
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    state_d    = state_q;
    next_key_d = next_key_q;
    rr_d       = rr_q;
    issued_d   = blocks_issued;
    exh_d      = exhausted;
    grant_d    = '0;
    base_d     = grant_base;
    last_d     = grant_last;
    core_d     = grant_core;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          next_key_d = '0;
          rr_d       = '0;
          issued_d   = '0;
          exh_d      = 1'b0;
        end
      end
      StRun: begin
        if (kill) begin
          state_d = StDone;
        end else if (found) begin
          grant_d[winner] = 1'b1;
          base_d     = next_key_q[KEY_WIDTH-1:0];
          last_d     = is_final ? KEY_MAX : block_end[KEY_WIDTH-1:0];
          core_d     = winner;
          next_key_d = next_key_q + BlockSize;
          rr_d       = (winner == LastCore) ? '0 : winner + 1'b1;
          issued_d   = (&blocks_issued) ? blocks_issued : blocks_issued + KEY_WIDTH'(1);
          if (is_final) begin
            state_d = StDone;
            exh_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      next_key_q    <= '0;
      rr_q          <= '0;
      req_q         <= '0;
      grant         <= '0;
      grant_base    <= '0;
      grant_last    <= '0;
      grant_core    <= '0;
      busy          <= 1'b0;
      exhausted     <= 1'b0;
      blocks_issued <= '0;
    end else begin
      state_q       <= state_d;
      next_key_q    <= next_key_d;
      rr_q          <= rr_d;
      req_q         <= req;
      grant         <= grant_d;
      grant_base    <= base_d;
      grant_last    <= last_d;
      grant_core    <= core_d;
      busy          <= (state_d == StRun);
      exhausted     <= exh_d;
      blocks_issued <= issued_d;
    end
  end

endmodule

// File: tb/tb_key_block_dispatcher.sv
// Bench for key_block_dispatcher: three small instances (KEY_MAX 0x3F, 0x25, 0xFF) on shared inputs,
// grants checked against a queue of expected {core, base, last, exhausted} records.
module tb_key_block_dispatcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       kill = 1'b0;
  logic [3:0] req = '0;

  logic [3:0] grant_v  [3];
  logic [7:0] base_v   [3];
  logic [7:0] last_v   [3];
  logic [1:0] core_v   [3];
  logic       busy_v   [3];
  logic       exh_v    [3];
  logic [7:0] issued_v [3];

  always #5 clk = ~clk;

  key_block_dispatcher #(.NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(8), .KEY_MAX(8'h3F),
                         .BLOCK_LOG(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .req(req), .grant(grant_v[0]),
    .grant_base(base_v[0]), .grant_last(last_v[0]), .grant_core(core_v[0]), .busy(busy_v[0]),
    .exhausted(exh_v[0]), .blocks_issued(issued_v[0]));

  key_block_dispatcher #(.NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(8), .KEY_MAX(8'h25),
                         .BLOCK_LOG(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .req(req), .grant(grant_v[1]),
    .grant_base(base_v[1]), .grant_last(last_v[1]), .grant_core(core_v[1]), .busy(busy_v[1]),
    .exhausted(exh_v[1]), .blocks_issued(issued_v[1]));

  key_block_dispatcher #(.NUM_CORES(4), .LOG_NUM_CORES(2), .KEY_WIDTH(8), .KEY_MAX(8'hFF),
                         .BLOCK_LOG(4)) dut_c (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .req(req), .grant(grant_v[2]),
    .grant_base(base_v[2]), .grant_last(last_v[2]), .grant_core(core_v[2]), .busy(busy_v[2]),
    .exhausted(exh_v[2]), .blocks_issued(issued_v[2]));

  typedef struct {
    logic [3:0] req;
    logic [1:0] core;
    logic [7:0] base;
    logic [7:0] last;
    logic       exh;
  } vec_t;

  vec_t tbl_full [4];
  vec_t tbl_short[3];
  vec_t tbl_alt  [6];
  vec_t exp_q[$];

  int         vectors = 0;
  int         miscompares = 0;
  int         sel = 0;
  logic [3:0] prev_g = '0;
  logic [3:0] cur_g = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge and score any grant against the queue.
  task automatic cycle();
    vec_t e;
    @(negedge clk);
    cur_g = grant_v[sel];
    if (cur_g != 0) begin
      chk("no_back_to_back", cur_g & prev_g, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", cur_g, 0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_onehot", cur_g, 4'b0001 << e.core);
        chk("grant_core", core_v[sel], e.core);
        chk("grant_base", base_v[sel], e.base);
        chk("grant_last", last_v[sel], e.last);
        chk("exh_with_grant", exh_v[sel], e.exh);
      end
    end
    prev_g = cur_g;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      cycle();
      if (cur_g != 0) seen++;
    end
    chk("grants_seen", seen, n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    start = 1'b0;
    kill  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    prev_g = '0;
  endtask

  initial begin
    int cnt;
    tbl_full[0]  = '{4'hF, 2'd0, 8'h00, 8'h0F, 1'b0};
    tbl_full[1]  = '{4'hF, 2'd1, 8'h10, 8'h1F, 1'b0};
    tbl_full[2]  = '{4'hF, 2'd2, 8'h20, 8'h2F, 1'b0};
    tbl_full[3]  = '{4'hF, 2'd3, 8'h30, 8'h3F, 1'b1};
    tbl_short[0] = '{4'h1, 2'd0, 8'h00, 8'h0F, 1'b0};
    tbl_short[1] = '{4'h1, 2'd0, 8'h10, 8'h1F, 1'b0};
    tbl_short[2] = '{4'h1, 2'd0, 8'h20, 8'h25, 1'b1};
    for (int i = 0; i < 6; i++)
      tbl_alt[i] = '{4'hA, (i % 2 == 0) ? 2'd1 : 2'd3, 8'(i * 16), 8'(i * 16 + 15), 1'b0};

    // Reset values.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_grant", grant_v[d], 0);
      chk("rst_base", base_v[d], 0);
      chk("rst_last", last_v[d], 0);
      chk("rst_core", core_v[d], 0);
      chk("rst_busy", busy_v[d], 0);
      chk("rst_exh", exh_v[d], 0);
      chk("rst_issued", issued_v[d], 0);
    end

    // Full sweep: four cores, four blocks, exhaustion on the last.
    do_reset();
    sel = 0;
    foreach (tbl_full[i]) exp_q.push_back(tbl_full[i]);
    req = tbl_full[0].req;
    pulse_start();
    chk("busy_after_start", busy_v[0], 1);
    wait_grants(4, 10);
    chk("t1_busy", busy_v[0], 0);
    chk("t1_exh", exh_v[0], 1);
    chk("t1_issued", issued_v[0], 4);
    repeat (4) cycle();
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_base_held", base_v[0], 8'h30);

    // Single requester with partial final block.
    do_reset();
    sel = 1;
    foreach (tbl_short[i]) exp_q.push_back(tbl_short[i]);
    req = tbl_short[0].req;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (cur_g[0]) begin
        req[0] = 1'b0;
        cnt = 2;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) req[0] = 1'b1;
      end
    end
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_exh", exh_v[1], 1);
    chk("t2_last", last_v[1], 8'h25);
    chk("t2_issued", issued_v[1], 3);

    // Alternating cores 1 and 3, then kill with requests still pending.
    do_reset();
    sel = 2;
    foreach (tbl_alt[i]) exp_q.push_back(tbl_alt[i]);
    req = tbl_alt[0].req;
    pulse_start();
    wait_grants(6, 12);
    kill = 1'b1;
    cycle();
    kill = 1'b0;
    chk("kill_busy", busy_v[2], 0);
    chk("kill_exh", exh_v[2], 0);
    repeat (6) cycle();
    chk("kill_issued", issued_v[2], 6);
    chk("kill_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-RUN, then restart from key 0.
    do_reset();
    sel = 2;
    exp_q.push_back(tbl_full[0]);
    exp_q.push_back(tbl_full[1]);
    req = 4'hF;
    pulse_start();
    wait_grants(2, 8);
    #2 reset = 1'b1;
    #1;
    chk("ar_grant", grant_v[2], 0);
    chk("ar_base", base_v[2], 0);
    chk("ar_last", last_v[2], 0);
    chk("ar_core", core_v[2], 0);
    chk("ar_busy", busy_v[2], 0);
    chk("ar_exh", exh_v[2], 0);
    chk("ar_issued", issued_v[2], 0);
    cycle();
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(tbl_full[0]);
    pulse_start();
    wait_grants(1, 6);
    chk("ar_restart_issued", issued_v[2], 1);
    kill = 1'b1;
    cycle();
    kill = 1'b0;

    // start during RUN is ignored; start in DONE restarts.
    do_reset();
    sel = 0;
    foreach (tbl_full[i]) exp_q.push_back(tbl_full[i]);
    req = 4'hF;
    pulse_start();
    wait_grants(2, 6);
    start = 1'b1;
    wait_grants(1, 3);
    start = 1'b0;
    wait_grants(1, 4);
    chk("t6_exh", exh_v[0], 1);
    chk("t6_issued", issued_v[0], 4);
    foreach (tbl_full[i]) exp_q.push_back(tbl_full[i]);
    pulse_start();
    chk("t6_exh_cleared", exh_v[0], 0);
    chk("t6_issued_cleared", issued_v[0], 0);
    wait_grants(4, 10);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_exh_again", exh_v[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
